// File: rtl/mem_stage_lsu_if.sv
`default_nettype none
// ============================================================================
// mem_stage_lsu_if : request/response bundle between the pipeline and the LSU
// Revision 1.0
// ============================================================================
interface mem_stage_lsu_if #(
   parameter int XLEN = 32
) ();
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] opr_res;
   logic [XLEN-1:0] store_data;
   logic            mem_rd;
   logic            mem_wr;
   logic [1:0]      mem_size;
   logic            mem_unsigned;
   logic [4:0]      rd;
   logic            wb_en;
   logic [1:0]      wb_sel;

   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_rdata;
   logic [XLEN-1:0] out_opr_res;
   logic [4:0]      out_rd;
   logic            out_wb_en;
   logic [1:0]      out_wb_sel;
   logic            out_misalign;

   modport master (
      output in_valid, opr_res, store_data, mem_rd, mem_wr, mem_size, mem_unsigned,
             rd, wb_en, wb_sel, out_ready,
      input  in_ready, out_valid, out_rdata, out_opr_res, out_rd, out_wb_en,
             out_wb_sel, out_misalign
   );

   modport slave (
      input  in_valid, opr_res, store_data, mem_rd, mem_wr, mem_size, mem_unsigned,
             rd, wb_en, wb_sel, out_ready,
      output in_ready, out_valid, out_rdata, out_opr_res, out_rd, out_wb_en,
             out_wb_sel, out_misalign
   );
endinterface
`default_nettype wire

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// mem_stage_lsu : pipeline memory stage with a LAT-cycle word-addressed data RAM
// Revision 1.0
// ============================================================================
module mem_stage_lsu #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 13,
   parameter int LAT    = 1
) (
   input  logic             clk,
   input  logic             arst,
   mem_stage_lsu_if.slave   bus
);
   localparam int DEPTH = 2 ** (ADDR_W - 2);

   typedef enum logic {IDLE, WAIT} state_t;

   typedef struct packed {
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] data;
      logic [1:0]      size;
      logic            uns;
      logic            ld;
      logic            st;
      logic [4:0]      rd;
      logic            wb_en;
      logic [1:0]      wb_sel;
   } req_t;

   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
      case (size)
         2'b00:   return 1'b0;
         2'b01:   return a[0];
         default: return a != 2'b00;
      endcase
   endfunction

   state_t          state_q, state_d;
   logic [2:0]      cnt_q, cnt_d;
   req_t            req_q, req_d;
   logic            out_valid_q, out_valid_d;
   logic            out_misalign_q, out_misalign_d;
   logic [XLEN-1:0] out_rdata_q, out_rdata_d;
   logic [XLEN-1:0] out_opr_res_q, out_opr_res_d;
   logic [4:0]      out_rd_q, out_rd_d;
   logic            out_wb_en_q, out_wb_en_d;
   logic [1:0]      out_wb_sel_q, out_wb_sel_d;

   req_t             in_req, cur;
   logic             in_ready, accept, in_mis, cur_mis, go_wait, wait_done, access, complete;
   logic [31:0]      mem [DEPTH];
   logic [ADDR_W-3:0] mem_idx;
   logic [31:0]      rd_word, rd_shift, st_wdata;
   logic [3:0]       st_be;
   logic             mem_we;
   logic [XLEN-1:0]  ld_ext;

   // A store with mem_rd also set behaves as a plain store.
   always_comb begin
      in_req.addr   = bus.opr_res;
      in_req.data   = bus.store_data;
      in_req.size   = bus.mem_size;
      in_req.uns    = bus.mem_unsigned;
      in_req.ld     = bus.mem_rd && !bus.mem_wr;
      in_req.st     = bus.mem_wr;
      in_req.rd     = bus.rd;
      in_req.wb_en  = bus.wb_en;
      in_req.wb_sel = bus.wb_sel;
   end

   assign in_ready  = !arst && (state_q == IDLE) && (!out_valid_q || bus.out_ready);
   assign accept    = bus.in_valid && in_ready;
   assign in_mis    = (in_req.ld || in_req.st) && misaligned(in_req.size, in_req.addr[1:0]);
   assign go_wait   = accept && (in_req.ld || in_req.st) && !in_mis && (LAT != 0);
   assign wait_done = (state_q == WAIT) && (cnt_q == 3'd1);
   assign cur       = (state_q == WAIT) ? req_q : in_req;
   assign cur_mis   = (cur.ld || cur.st) && misaligned(cur.size, cur.addr[1:0]);
   assign access    = wait_done ||
                      (accept && (in_req.ld || in_req.st) && !in_mis && (LAT == 0));
   assign complete  = (accept && !go_wait) || wait_done;

   assign mem_idx  = cur.addr[ADDR_W-1:2];
   assign rd_word  = mem[mem_idx];
   assign rd_shift = rd_word >> {cur.addr[1:0], 3'b000};
   assign mem_we   = access && cur.st;

   always_comb begin
      case (cur.size)
         2'b00: begin
            st_be    = 4'b0001 << cur.addr[1:0];
            st_wdata = {4{cur.data[7:0]}};
            ld_ext   = cur.uns ? XLEN'(rd_shift[7:0]) : {{(XLEN-8){rd_shift[7]}}, rd_shift[7:0]};
         end
         2'b01: begin
            st_be    = cur.addr[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{cur.data[15:0]}};
            ld_ext   = cur.uns ? XLEN'(rd_shift[15:0])
                               : {{(XLEN-16){rd_shift[15]}}, rd_shift[15:0]};
         end
         default: begin
            st_be    = 4'b1111;
            st_wdata = cur.data[31:0];
            ld_ext   = XLEN'(rd_word);
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (st_be[b]) mem[mem_idx][b*8 +: 8] <= st_wdata[b*8 +: 8];
         end
      end
   end

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      req_d          = req_q;
      out_valid_d    = out_valid_q;
      out_misalign_d = out_misalign_q;
      out_rdata_d    = out_rdata_q;
      out_opr_res_d  = out_opr_res_q;
      out_rd_d       = out_rd_q;
      out_wb_en_d    = out_wb_en_q;
      out_wb_sel_d   = out_wb_sel_q;

      case (state_q)
         IDLE: begin
            if (go_wait) begin
               state_d = WAIT;
               cnt_d   = 3'(LAT);
               req_d   = in_req;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (complete) begin
         out_valid_d    = 1'b1;
         out_misalign_d = cur_mis;
         out_rdata_d    = (access && cur.ld) ? ld_ext : '0;
         out_opr_res_d  = cur.addr;
         out_rd_d       = cur.rd;
         out_wb_en_d    = cur.wb_en && !cur_mis;
         out_wb_sel_d   = cur.wb_sel;
      end else if (bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q        <= IDLE;
         cnt_q          <= 3'd0;
         req_q          <= '0;
         out_valid_q    <= 1'b0;
         out_misalign_q <= 1'b0;
         out_rdata_q    <= '0;
         out_opr_res_q  <= '0;
         out_rd_q       <= 5'd0;
         out_wb_en_q    <= 1'b0;
         out_wb_sel_q   <= 2'd0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         req_q          <= req_d;
         out_valid_q    <= out_valid_d;
         out_misalign_q <= out_misalign_d;
         out_rdata_q    <= out_rdata_d;
         out_opr_res_q  <= out_opr_res_d;
         out_rd_q       <= out_rd_d;
         out_wb_en_q    <= out_wb_en_d;
         out_wb_sel_q   <= out_wb_sel_d;
      end
   end

   assign bus.in_ready     = in_ready;
   assign bus.out_valid    = out_valid_q;
   assign bus.out_misalign = out_misalign_q;
   assign bus.out_rdata    = out_rdata_q;
   assign bus.out_opr_res  = out_opr_res_q;
   assign bus.out_rd       = out_rd_q;
   assign bus.out_wb_en    = out_wb_en_q;
   assign bus.out_wb_sel   = out_wb_sel_q;
endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// tb_mem_stage_lsu : scoreboard bench driving a LAT=0 and a LAT=3 instance
// Revision 1.0
// ============================================================================
module tb_mem_stage_lsu;
   typedef struct packed {
      logic [31:0] rdata;
      logic [31:0] opr;
      logic [4:0]  rd;
      logic        wb_en;
      logic [1:0]  wb_sel;
      logic        mis;
   } exp_t;

   logic        clk = 1'b0;
   logic        arst = 1'b1;
   logic        sel = 1'b0;
   logic        t_valid = 1'b0;
   logic [31:0] t_opr = '0, t_sd = '0;
   logic        t_rd_en = 1'b0, t_wr_en = 1'b0, t_uns = 1'b0, t_wb_en = 1'b0;
   logic [1:0]  t_size = '0, t_wb_sel = '0;
   logic [4:0]  t_rd = '0;
   logic        rdy0 = 1'b1, rdy3 = 1'b1;
   logic [4:0]  next_rd = 5'd1;

   int   n_vec = 0;
   int   n_miss = 0;
   exp_t q0[$];
   exp_t q3[$];

   always #5 clk = ~clk;

   mem_stage_lsu_if #(.XLEN(32)) b0 ();
   mem_stage_lsu_if #(.XLEN(32)) b3 ();

   assign b0.in_valid = t_valid && !sel;    assign b3.in_valid = t_valid && sel;
   assign b0.opr_res = t_opr;               assign b3.opr_res = t_opr;
   assign b0.store_data = t_sd;             assign b3.store_data = t_sd;
   assign b0.mem_rd = t_rd_en;              assign b3.mem_rd = t_rd_en;
   assign b0.mem_wr = t_wr_en;              assign b3.mem_wr = t_wr_en;
   assign b0.mem_size = t_size;             assign b3.mem_size = t_size;
   assign b0.mem_unsigned = t_uns;          assign b3.mem_unsigned = t_uns;
   assign b0.rd = t_rd;                     assign b3.rd = t_rd;
   assign b0.wb_en = t_wb_en;               assign b3.wb_en = t_wb_en;
   assign b0.wb_sel = t_wb_sel;             assign b3.wb_sel = t_wb_sel;
   assign b0.out_ready = rdy0;              assign b3.out_ready = rdy3;

   mem_stage_lsu #(.XLEN(32), .ADDR_W(13), .LAT(0)) u_dut0 (.clk(clk), .arst(arst), .bus(b0));
   mem_stage_lsu #(.XLEN(32), .ADDR_W(13), .LAT(3)) u_dut3 (.clk(clk), .arst(arst), .bus(b3));

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
      n_vec++;
      if (act !== req) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   task automatic score(input string name, input exp_t g, input exp_t e);
      n_vec++;
      if (g !== e) begin
         n_miss++;
         $display("FAIL %s: got rdata=%h opr=%h rd=%0d wb_en=%b wb_sel=%0d mis=%b, required rdata=%h opr=%h rd=%0d wb_en=%b wb_sel=%0d mis=%b",
                  name, g.rdata, g.opr, g.rd, g.wb_en, g.wb_sel, g.mis,
                  e.rdata, e.opr, e.rd, e.wb_en, e.wb_sel, e.mis);
      end
   endtask

   initial begin
      exp_t g, e;
      forever begin
         @(negedge clk);
         if (b0.out_valid === 1'b1 && b0.out_ready === 1'b1) begin
            g = {b0.out_rdata, b0.out_opr_res, b0.out_rd, b0.out_wb_en, b0.out_wb_sel, b0.out_misalign};
            if (q0.size() == 0) begin
               n_vec++; n_miss++;
               $display("FAIL out0_unexpected: got %h, required no output", g);
            end else begin
               e = q0.pop_front();
               score("out0", g, e);
            end
         end
      end
   end

   initial begin
      exp_t g, e;
      forever begin
         @(negedge clk);
         if (b3.out_valid === 1'b1 && b3.out_ready === 1'b1) begin
            g = {b3.out_rdata, b3.out_opr_res, b3.out_rd, b3.out_wb_en, b3.out_wb_sel, b3.out_misalign};
            if (q3.size() == 0) begin
               n_vec++; n_miss++;
               $display("FAIL out3_unexpected: got %h, required no output", g);
            end else begin
               e = q3.pop_front();
               score("out3", g, e);
            end
         end
      end
   end

   // Issues one request to DUT s and queues the hand-computed response.
   task automatic op(input bit s, input bit rq, input bit wq, input logic [1:0] sz,
                     input bit un, input logic [31:0] a, input logic [31:0] d, input bit we,
                     input logic [31:0] er, input bit em, input bit push);
      int   waits;
      exp_t e;
      sel = s; t_rd_en = rq; t_wr_en = wq; t_size = sz; t_uns = un;
      t_opr = a; t_sd = d; t_wb_en = we; t_rd = next_rd; t_wb_sel = next_rd[1:0];
      t_valid = 1'b1;
      waits = 0;
      forever begin
         @(negedge clk);
         if ((s ? b3.in_ready : b0.in_ready) === 1'b1) break;
         waits++;
         if (waits > 50) begin
            $display("FAIL accept_timeout: got no in_ready after %0d cycles, required accept", waits);
            n_vec++; n_miss++;
            t_valid = 1'b0;
            return;
         end
      end
      @(posedge clk); #1;
      t_valid = 1'b0;
      if (push) begin
         e = {er, a, next_rd, we & ~em, next_rd[1:0], em};
         if (s) q3.push_back(e);
         else   q0.push_back(e);
      end
      if (!s) chk("lat0_accept_wait", 96'(waits), 96'd0);
      next_rd = next_rd + 5'd1;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_in_ready", {b0.in_ready, b3.in_ready}, 96'd0);
      chk("rst_ctl0", {b0.out_valid, b0.out_misalign, b0.out_rd, b0.out_wb_en, b0.out_wb_sel}, 96'd0);
      chk("rst_data0", {b0.out_rdata, b0.out_opr_res}, 96'd0);
      chk("rst_ctl3", {b3.out_valid, b3.out_misalign, b3.out_rd, b3.out_wb_en, b3.out_wb_sel}, 96'd0);
      @(posedge clk); #1;
      arst = 1'b0;
      @(negedge clk);
      chk("rel_in_ready", {b0.in_ready, b3.in_ready}, 96'b11);
      @(posedge clk); #1;

      // LAT=0 instance: back-to-back stores, loads, misaligned and non-memory ops
      op(0, 0, 1, 2'b10, 0, 32'h100,  32'hDEADBEEF, 0, 32'h0,        0, 1);
      op(0, 1, 0, 2'b00, 0, 32'h103,  32'h0,        1, 32'hFFFFFFDE, 0, 1);
      op(0, 1, 0, 2'b00, 1, 32'h103,  32'h0,        1, 32'h000000DE, 0, 1);
      op(0, 0, 1, 2'b10, 0, 32'h100,  32'hAABBCCDD, 0, 32'h0,        0, 1);
      op(0, 0, 1, 2'b01, 0, 32'h102,  32'h99991234, 0, 32'h0,        0, 1);
      op(0, 1, 0, 2'b10, 0, 32'h100,  32'h0,        1, 32'h1234CCDD, 0, 1);
      op(0, 1, 0, 2'b01, 0, 32'h100,  32'h0,        1, 32'hFFFFCCDD, 0, 1);
      op(0, 1, 0, 2'b01, 1, 32'h102,  32'h0,        1, 32'h00001234, 0, 1);
      op(0, 0, 1, 2'b00, 0, 32'h101,  32'h0000005A, 0, 32'h0,        0, 1);
      op(0, 1, 0, 2'b10, 0, 32'h100,  32'h0,        1, 32'h12345ADD, 0, 1);
      op(0, 1, 0, 2'b00, 0, 32'h101,  32'h0,        1, 32'h0000005A, 0, 1);
      op(0, 1, 0, 2'b11, 0, 32'h101,  32'h0,        1, 32'h0,        1, 1);
      op(0, 0, 1, 2'b10, 0, 32'h102,  32'hFFFFFFFF, 0, 32'h0,        1, 1);
      op(0, 0, 1, 2'b01, 0, 32'h103,  32'h0000FFFF, 0, 32'h0,        1, 1);
      op(0, 1, 0, 2'b00, 1, 32'h103,  32'h0,        1, 32'h00000012, 0, 1);
      op(0, 1, 0, 2'b10, 0, 32'h100,  32'h0,        1, 32'h12345ADD, 0, 1);
      op(0, 0, 0, 2'b10, 0, 32'h12345677, 32'h0,    1, 32'h0,        0, 1);
      op(0, 1, 1, 2'b10, 0, 32'h200,  32'hCAFEF00D, 1, 32'h0,        0, 1);
      op(0, 1, 0, 2'b10, 0, 32'h200,  32'h0,        1, 32'hCAFEF00D, 0, 1);
      op(0, 1, 0, 2'b10, 0, 32'h2100, 32'h0,        1, 32'h12345ADD, 0, 1);
      repeat (2) @(posedge clk); #1;

      // Downstream stall: result must hold and upstream must be blocked
      rdy0 = 1'b0;
      op(0, 1, 0, 2'b10, 0, 32'h100, 32'h0, 1, 32'h12345ADD, 0, 1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("stall_hold", {b0.out_valid, b0.in_ready, b0.out_rdata, b0.out_opr_res},
             {1'b1, 1'b0, 32'h12345ADD, 32'h100});
      end
      @(posedge clk); #1;
      rdy0 = 1'b1;
      op(0, 1, 0, 2'b00, 1, 32'h100, 32'h0, 1, 32'h000000DD, 0, 1);

      // LAT=3 instance: store, timed load, misaligned bypass, half store
      op(1, 0, 1, 2'b10, 0, 32'h200, 32'h11223344, 0, 32'h0, 0, 1);
      op(1, 1, 0, 2'b10, 0, 32'h200, 32'h0,        1, 32'h11223344, 0, 1);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         chk("lat3_wait", {b3.in_ready, b3.out_valid}, 96'b00);
      end
      @(negedge clk);
      chk("lat3_done", 96'(b3.out_valid), 96'd1);
      @(posedge clk); #1;
      op(1, 1, 0, 2'b01, 0, 32'h201, 32'h0, 1, 32'h0, 1, 1);
      @(negedge clk);
      chk("lat3_misalign_lat", 96'(b3.out_valid), 96'd1);
      @(posedge clk); #1;
      op(1, 0, 1, 2'b01, 0, 32'h202, 32'h0000BEEF, 0, 32'h0,        0, 1);
      op(1, 1, 0, 2'b10, 0, 32'h200, 32'h0,        1, 32'hBEEF3344, 0, 1);
      repeat (6) @(posedge clk); #1;

      // Reset in the first WAIT cycle of a store aborts it
      op(1, 0, 1, 2'b10, 0, 32'h200, 32'hDEADDEAD, 0, 32'h0, 0, 0);
      arst = 1'b1;
      @(negedge clk);
      chk("abort_rst", {b3.in_ready, b3.out_valid, b0.out_valid, b3.out_opr_res}, 96'd0);
      repeat (4) @(posedge clk); #1;
      arst = 1'b0;
      op(1, 1, 0, 2'b10, 0, 32'h200, 32'h0, 1, 32'hBEEF3344, 0, 1);
      op(0, 1, 0, 2'b10, 0, 32'h100, 32'h0, 1, 32'h12345ADD, 0, 1);

      for (int i = 0; i < 30 && (q0.size() + q3.size()) != 0; i++) @(posedge clk);
      @(negedge clk);
      chk("drain", 96'(q0.size() + q3.size()), 96'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
`default_nettype wire
